// File: rtl/hu_audiodec_dma_pkg.sv
// Shared types and constants for the audio-decoder DMA read front-end.
// Covers the control-request message layout and the read FSM encoding.
package hu_audiodec_dma_pkg;

    localparam int DMA_W = 64;
    localparam int WORD_W = 32;
    localparam logic [2:0] DMA_SIZE_64 = 3'b011;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_XFER,
        ST_FIN
    } state_t;

    typedef struct packed {
        logic [2:0]  size;
        logic [31:0] length;
        logic [31:0] index;
    } dma_ctrl_msg_t;

    // Two 32-bit words per 64-bit beat; nwords never reaches 2^32-1, so the add cannot wrap.
    function automatic logic [31:0] beat_count(input logic [31:0] nwords);
        return (nwords + 32'd1) >> 1;
    endfunction

endpackage

// File: rtl/hu_audiodec_beat_splitter.sv
// One-beat holding register that presents a 64-bit DMA beat as two 32-bit words.
// Low half goes out first; a new beat is taken the same cycle the buffer frees.
module hu_audiodec_beat_splitter
    import hu_audiodec_dma_pkg::*;
#(
    parameter int DMA_W  = hu_audiodec_dma_pkg::DMA_W,
    parameter int WORD_W = hu_audiodec_dma_pkg::WORD_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              is_last,
    input  logic              chnl_valid,
    output logic              chnl_ready,
    input  logic [DMA_W-1:0]  chnl_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data
);

    logic [DMA_W-1:0] hold_data;
    logic             hold_valid;
    logic             half;
    logic             word_fire;
    logic             hold_free;
    logic             beat_fire;

    // The final word frees the buffer even from the low half, dropping the unused high half.
    assign word_fire  = hold_valid && out_ready;
    assign hold_free  = word_fire && (half || is_last);
    assign chnl_ready = enable && (!hold_valid || (hold_free && !is_last));
    assign beat_fire  = chnl_valid && chnl_ready;

    assign out_valid = hold_valid;
    assign out_data  = half ? hold_data[DMA_W-1:WORD_W] : hold_data[WORD_W-1:0];

    // NOTE: non-blocking assignments keep every register updating from pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            // NOTE: the data register is reset too, so out_data reads zero after reset.
            hold_data  <= '0;
            hold_valid <= 1'b0;
            half       <= 1'b0;
        end else if (beat_fire) begin
            hold_data  <= chnl_data;
            hold_valid <= 1'b1;
            half       <= 1'b0;
        end else if (hold_free) begin
            hold_valid <= 1'b0;
            half       <= 1'b0;
        end else if (word_fire) begin
            half <= 1'b1;
        end
    end

endmodule

// File: rtl/hu_audiodec_dma64_rd_unpack.sv
// DMA read front-end: issues one read request, then streams the returned beats
// as 32-bit words with last-word marking and a completion pulse.
module hu_audiodec_dma64_rd_unpack
    import hu_audiodec_dma_pkg::*;
#(
    parameter int         DMA_W    = hu_audiodec_dma_pkg::DMA_W,
    parameter int         WORD_W   = hu_audiodec_dma_pkg::WORD_W,
    parameter logic [2:0] DMA_SIZE = hu_audiodec_dma_pkg::DMA_SIZE_64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [31:0]       cfg_index,
    input  logic [31:0]       cfg_nwords,
    output logic              busy,
    output logic              done,
    output logic              dma_read_ctrl_valid,
    input  logic              dma_read_ctrl_ready,
    output logic [31:0]       dma_read_ctrl_data_index,
    output logic [31:0]       dma_read_ctrl_data_length,
    output logic [2:0]        dma_read_ctrl_data_size,
    input  logic              dma_read_chnl_valid,
    output logic              dma_read_chnl_ready,
    input  logic [DMA_W-1:0]  dma_read_chnl_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WORD_W-1:0] out_data,
    output logic              out_last
);

    state_t        state;
    state_t        next_state;
    dma_ctrl_msg_t ctrl_q;
    logic [31:0]   words_left;
    logic          is_last;
    logic          word_fire;
    logic          load_cfg;

    assign is_last   = (words_left == 32'd1);
    assign word_fire = out_valid && out_ready;
    assign load_cfg  = (state == ST_IDLE) && start && (cfg_nwords != 32'd0);

    // NOTE: next_state gets its default first so no path through the case infers a latch.
    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: if (start) next_state = (cfg_nwords == 32'd0) ? ST_FIN : ST_REQ;
            ST_REQ:  if (dma_read_ctrl_ready) next_state = ST_XFER;
            ST_XFER: if (word_fire && is_last) next_state = ST_FIN;
            ST_FIN:  next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl_q     <= '{size: DMA_SIZE, length: '0, index: '0};
            words_left <= '0;
        end else if (load_cfg) begin
            ctrl_q     <= '{size: DMA_SIZE, length: beat_count(cfg_nwords), index: cfg_index};
            words_left <= cfg_nwords;
        end else if (word_fire) begin
            words_left <= words_left - 32'd1;
        end
    end

    assign busy                      = (state != ST_IDLE);
    assign done                      = (state == ST_FIN);
    assign dma_read_ctrl_valid       = (state == ST_REQ);
    assign dma_read_ctrl_data_index  = ctrl_q.index;
    assign dma_read_ctrl_data_length = ctrl_q.length;
    assign dma_read_ctrl_data_size   = ctrl_q.size;
    assign out_last                  = out_valid && is_last;

    hu_audiodec_beat_splitter #(
        .DMA_W  (DMA_W),
        .WORD_W (WORD_W)
    ) u_splitter (
        .clk        (clk),
        .rst        (rst),
        .enable     (state == ST_XFER),
        .is_last    (is_last),
        .chnl_valid (dma_read_chnl_valid),
        .chnl_ready (dma_read_chnl_ready),
        .chnl_data  (dma_read_chnl_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data)
    );

endmodule

// File: tb/tb_hu_audiodec_dma64_rd_unpack.sv
// Directed bench for the DMA read unpacker: each step drives a transfer and
// checks control fields, word order, last marking and the done pulse.
module tb_hu_audiodec_dma64_rd_unpack;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [31:0] cfg_index;
    logic [31:0] cfg_nwords;
    logic        busy;
    logic        done;
    logic        dma_read_ctrl_valid;
    logic        dma_read_ctrl_ready;
    logic [31:0] dma_read_ctrl_data_index;
    logic [31:0] dma_read_ctrl_data_length;
    logic [2:0]  dma_read_ctrl_data_size;
    logic        dma_read_chnl_valid;
    logic        dma_read_chnl_ready;
    logic [63:0] dma_read_chnl_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;

    int          n_asserts = 0;
    int          n_fails = 0;
    logic [63:0] beat_q[$];
    logic [31:0] word_q[$];
    int          span;

    always #5 clk = ~clk;

    hu_audiodec_dma64_rd_unpack dut (
        .clk                       (clk),
        .rst                       (rst),
        .start                     (start),
        .cfg_index                 (cfg_index),
        .cfg_nwords                (cfg_nwords),
        .busy                      (busy),
        .done                      (done),
        .dma_read_ctrl_valid       (dma_read_ctrl_valid),
        .dma_read_ctrl_ready       (dma_read_ctrl_ready),
        .dma_read_ctrl_data_index  (dma_read_ctrl_data_index),
        .dma_read_ctrl_data_length (dma_read_ctrl_data_length),
        .dma_read_ctrl_data_size   (dma_read_ctrl_data_size),
        .dma_read_chnl_valid       (dma_read_chnl_valid),
        .dma_read_chnl_ready       (dma_read_chnl_ready),
        .dma_read_chnl_data        (dma_read_chnl_data),
        .out_valid                 (out_valid),
        .out_ready                 (out_ready),
        .out_data                  (out_data),
        .out_last                  (out_last)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns at the negedge after the start edge.
    task automatic kick(input logic [31:0] idx, input logic [31:0] nw);
        @(negedge clk);
        cfg_index  = idx;
        cfg_nwords = nw;
        start      = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Called in REQ; holds ctrl_ready low for `stall` cycles, then handshakes.
    task automatic do_ctrl(input logic [31:0] idx, input logic [31:0] len, input int stall);
        for (int i = 0; i < stall; i++) begin
            check("req_valid_stall", dma_read_ctrl_valid, 1);
            check("req_index_stall", dma_read_ctrl_data_index, idx);
            check("req_length_stall", dma_read_ctrl_data_length, len);
            check("chnl_ready_in_req", dma_read_chnl_ready, 0);
            @(negedge clk);
        end
        check("req_valid", dma_read_ctrl_valid, 1);
        check("req_index", dma_read_ctrl_data_index, idx);
        check("req_length", dma_read_ctrl_data_length, len);
        check("req_size", dma_read_ctrl_data_size, 3'b011);
        dma_read_ctrl_ready = 1'b1;
        @(negedge clk);
        dma_read_ctrl_ready = 1'b0;
    endtask

    // Feeds beat_q, consumes words against word_q; returns at the negedge after the last word edge.
    task automatic do_xfer(input int nw, input bit toggle, input int abort_after,
                           input bit inject, output int span_o);
        int widx = 0;
        int bidx = 0;
        int first = -1;
        int last = -1;
        for (int c = 0; c < 200 && widx < nw; c++) begin
            start     = 1'b0;
            out_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (inject && widx == 1) begin
                start      = 1'b1;
                cfg_index  = 32'hFFFF_0000;
                cfg_nwords = 32'd9;
            end
            #1;
            if (out_valid && !out_ready) check("chnl_ready_while_held", dma_read_chnl_ready, 0);
            if (out_valid && out_ready) begin
                check("word_data", out_data, word_q[widx]);
                check("word_last", out_last, (widx == nw - 1));
                if (first < 0) first = c;
                last = c;
                widx++;
            end
            dma_read_chnl_valid = (bidx < beat_q.size());
            dma_read_chnl_data  = (bidx < beat_q.size()) ? beat_q[bidx] : 64'h0;
            #1;
            if (dma_read_chnl_valid && dma_read_chnl_ready) bidx++;
            if (abort_after > 0 && widx == abort_after) break;
            @(negedge clk);
        end
        if (abort_after == 0 && widx < nw) check("xfer_timeout_words", widx, nw);
        start               = 1'b0;
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = 64'h0;
        span_o              = last - first;
    endtask

    task automatic check_finish();
        check("fin_done", done, 1);
        check("fin_busy", busy, 1);
        check("fin_out_valid", out_valid, 0);
        @(negedge clk);
        check("idle_done", done, 0);
        check("idle_busy", busy, 0);
    endtask

    initial begin
        rst                 = 1'b0;
        start               = 1'b0;
        cfg_index           = '0;
        cfg_nwords          = '0;
        dma_read_ctrl_ready = 1'b0;
        dma_read_chnl_valid = 1'b0;
        dma_read_chnl_data  = '0;
        out_ready           = 1'b0;
        #12;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_ctrl_valid", dma_read_ctrl_valid, 0);
        check("rst_size", dma_read_ctrl_data_size, 3'b011);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        @(negedge clk);
        rst = 1'b1;

        // Spurious beat in IDLE is not accepted.
        @(negedge clk);
        dma_read_chnl_valid = 1'b1;
        #1;
        check("idle_chnl_ready", dma_read_chnl_ready, 0);
        dma_read_chnl_valid = 1'b0;

        // Four words, continuous flow.
        beat_q = '{64'h0000_0002_0000_0001, 64'h0000_0004_0000_0003};
        word_q = '{32'h1, 32'h2, 32'h3, 32'h4};
        kick(32'h10, 32'd4);
        do_ctrl(32'h10, 32'd2, 0);
        do_xfer(4, 1'b0, 0, 1'b0, span);
        check("four_words_consecutive", span, 3);
        check_finish();

        // Odd count: high half of the final beat is dropped.
        beat_q = '{64'hBBBB_AAAA_1111_0000, 64'hDEAD_BEEF_0000_0005};
        word_q = '{32'h1111_0000, 32'hBBBB_AAAA, 32'h0000_0005};
        kick(32'h44, 32'd3);
        do_ctrl(32'h44, 32'd2, 0);
        do_xfer(3, 1'b0, 0, 1'b0, span);
        check_finish();

        // Zero words: straight to FIN, no request.
        kick(32'h5, 32'd0);
        check("zero_ctrl_valid", dma_read_ctrl_valid, 0);
        check_finish();

        // Stalled request, then a throttled consumer.
        beat_q = '{64'h0000_00B2_0000_00B1, 64'h0000_00B4_0000_00B3, 64'h0000_00FF_0000_00B5};
        word_q = '{32'hB1, 32'hB2, 32'hB3, 32'hB4, 32'hB5};
        kick(32'h80, 32'd5);
        do_ctrl(32'h80, 32'd3, 5);
        do_xfer(5, 1'b1, 0, 1'b0, span);
        check_finish();

        // Reset mid-transfer after one word, then a fresh two-word transfer.
        beat_q = '{64'h0000_0A02_0000_0A01, 64'h0000_0A04_0000_0A03};
        word_q = '{32'hA01, 32'hA02, 32'hA03, 32'hA04};
        kick(32'h20, 32'd4);
        do_ctrl(32'h20, 32'd2, 0);
        do_xfer(4, 1'b0, 1, 1'b0, span);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check("abort_out_valid", out_valid, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        check("abort_index", dma_read_ctrl_data_index, 0);
        check("abort_length", dma_read_ctrl_data_length, 0);
        check("abort_chnl_ready", dma_read_chnl_ready, 0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("abort_no_done", done, 0);
        end
        beat_q = '{64'h0000_0C02_0000_0C01};
        word_q = '{32'hC01, 32'hC02};
        kick(32'h60, 32'd2);
        do_ctrl(32'h60, 32'd1, 0);
        do_xfer(2, 1'b0, 0, 1'b0, span);
        check("two_words_consecutive", span, 1);
        check_finish();

        // start during XFER with new cfg is ignored.
        beat_q = '{64'h0000_0D02_0000_0D01, 64'h0000_0D04_0000_0D03};
        word_q = '{32'hD01, 32'hD02, 32'hD03, 32'hD04};
        kick(32'h30, 32'd4);
        do_ctrl(32'h30, 32'd2, 0);
        do_xfer(4, 1'b0, 0, 1'b1, span);
        check_finish();
        check("kept_index", dma_read_ctrl_data_index, 32'h30);
        check("kept_length", dma_read_ctrl_data_length, 32'd2);
        repeat (2) @(negedge clk);
        check("no_requeued_start", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
